q_edge_monitor: RTL and testbench

Downstream observer for the JK flip-flop stage. Samples the flip-flop `q` output every clock and counts rising and falling transitions in saturating counters. Flags toggle events and saturation. Provides a request/acknowledge snapshot port so a checker or host can read coherent counts while counting continues.

---
 rtl/q_edge_monitor.sv | 176 +++++++++++++++++
 tb/tb_q_edge_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_edge_monitor.sv
// ---------------------------------------------------------------------------------------------
// q_edge_monitor
//
// Watches the q output of the JK flip-flop stage. Rising and falling transitions are counted
// in two saturating counters. A sticky flag reports when either counter has saturated. A
// registered toggle pulse marks any edge, and a registered copy of q is also provided. A
// request/acknowledge port lets a host take a coherent snapshot of both counters while
// counting continues.
//
// Ports:
//   clk_i        single clock, rising-edge active
//   rst_ni       asynchronous active-low reset; clears all state immediately
//   q_i          flip-flop q output (same clock domain, no synchronizer)
//   clr_i        synchronous clear of the live counters and sat_o
//   rd_req_i     snapshot request, sampled every cycle while idle
//   rd_ack_o     one-cycle pulse; snapshot outputs are valid
//   rise_snap_o  rising-edge count captured by the last accepted request
//   fall_snap_o  falling-edge count captured by the last accepted request
//   toggle_o     registered one-cycle pulse for any edge on q_i
//   level_o      registered copy of q_i
//   sat_o        sticky; either live counter has reached all-ones
// ---------------------------------------------------------------------------------------------
module q_edge_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             q_i,
    input  logic             clr_i,
    input  logic             rd_req_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rise_snap_o,
    output logic [CNT_W-1:0] fall_snap_o,
    output logic             toggle_o,
    output logic             level_o,
    output logic             sat_o
);

    if (CNT_W < 2 || CNT_W > 16) begin : gen_bad_width
        $error("q_edge_monitor: CNT_W must be in the range 2..16");
    end

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } hs_state_e;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic             prev_q;       // previous sample of q_i
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic             sat_q, sat_d;
    logic             toggle_q, toggle_d;
    logic             level_q;
    logic [CNT_W-1:0] rise_snap_q, rise_snap_d;
    logic [CNT_W-1:0] fall_snap_q, fall_snap_d;
    hs_state_e        state_q, state_d;

    logic rise_edge;
    logic fall_edge;

    // -----------------------------------------------------------------------------------------
    // Edge detection
    // -----------------------------------------------------------------------------------------
    // Until the first sample has been taken there is no valid previous level, so the level
    // present at reset release is never treated as an edge.
    always_comb begin
        rise_edge = armed_q & q_i & ~prev_q;
        fall_edge = armed_q & ~q_i & prev_q;
        armed_d   = 1'b1;
        toggle_d  = rise_edge | fall_edge;
    end

    // -----------------------------------------------------------------------------------------
    // Live counters and saturation flag
    // -----------------------------------------------------------------------------------------
    always_comb begin
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        sat_d      = sat_q;

        if (clr_i) begin
            // Clear wins over any edge detected in the same cycle.
            rise_cnt_d = '0;
            fall_cnt_d = '0;
            sat_d      = 1'b0;
        end else begin
            if (rise_edge && (rise_cnt_q != CntMax)) begin
                rise_cnt_d = rise_cnt_q + CntOne;
            end
            if (fall_edge && (fall_cnt_q != CntMax)) begin
                fall_cnt_d = fall_cnt_q + CntOne;
            end
            // Flag rises together with the counter reaching all-ones.
            if ((rise_cnt_d == CntMax) || (fall_cnt_d == CntMax)) begin
                sat_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Snapshot handshake
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rise_snap_d = rise_snap_q;
        fall_snap_d = fall_snap_q;

        unique case (state_q)
            StIdle: begin
                if (rd_req_i) begin
                    // Capture the counters as they stood at the start of this cycle, so an
                    // edge or clear in the same cycle only affects the live counters.
                    rise_snap_d = rise_cnt_q;
                    fall_snap_d = fall_cnt_q;
                    state_d     = StAck;
                end
            end
            StAck: begin
                // A request seen here is dropped, not queued.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            sat_q       <= 1'b0;
            toggle_q    <= 1'b0;
            level_q     <= 1'b0;
            rise_snap_q <= '0;
            fall_snap_q <= '0;
            state_q     <= StIdle;
        end else begin
            prev_q      <= q_i;
            armed_q     <= armed_d;
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
            sat_q       <= sat_d;
            toggle_q    <= toggle_d;
            level_q     <= q_i;
            rise_snap_q <= rise_snap_d;
            fall_snap_q <= fall_snap_d;
            state_q     <= state_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        rd_ack_o    = (state_q == StAck);
        rise_snap_o = rise_snap_q;
        fall_snap_o = fall_snap_q;
        toggle_o    = toggle_q;
        level_o     = level_q;
        sat_o       = sat_q;
    end

endmodule

// File: tb/tb_q_edge_monitor.sv
// ---------------------------------------------------------------------------------------------
// tb_q_edge_monitor
//
// Drives two instances (CNT_W=8 and CNT_W=2) with the same stimulus: directed scenarios
// followed by randomized traffic. A behavioural model keeps unbounded raw edge counts since the
// last clear and derives the saturated counts, flags and snapshots from them; a compare process
// checks every output of both instances on each falling clock edge. Literal checks pin the
// model on the directed scenarios.
// ---------------------------------------------------------------------------------------------
module tb_q_edge_monitor;

    localparam int unsigned W8 = 8;
    localparam int unsigned W2 = 2;
    localparam int Max8 = 255;
    localparam int Max2 = 3;

    logic clk;
    logic rst_n;
    logic q;
    logic clr;
    logic rd_req;

    logic          ack8, tog8, lvl8, sat8;
    logic [W8-1:0] rsnap8, fsnap8;
    logic          ack2, tog2, lvl2, sat2;
    logic [W2-1:0] rsnap2, fsnap2;

    q_edge_monitor #(.CNT_W(W8)) u_dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .q_i         (q),
        .clr_i       (clr),
        .rd_req_i    (rd_req),
        .rd_ack_o    (ack8),
        .rise_snap_o (rsnap8),
        .fall_snap_o (fsnap8),
        .toggle_o    (tog8),
        .level_o     (lvl8),
        .sat_o       (sat8)
    );

    q_edge_monitor #(.CNT_W(W2)) u_dut2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .q_i         (q),
        .clr_i       (clr),
        .rd_req_i    (rd_req),
        .rd_ack_o    (ack2),
        .rise_snap_o (rsnap2),
        .fall_snap_o (fsnap2),
        .toggle_o    (tog2),
        .level_o     (lvl2),
        .sat_o       (sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // -----------------------------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------------------------
    int m_raw_rise, m_raw_fall;      // edges seen since last clear/reset, unbounded
    int m_snap_rise[2], m_snap_fall[2];
    bit m_armed, m_prev, m_level, m_toggle, m_ack;

    function automatic int sat_val(input int raw, input int mx);
        return (raw > mx) ? mx : raw;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_raw_rise = 0; m_raw_fall = 0;
            m_snap_rise = '{0, 0}; m_snap_fall = '{0, 0};
            m_armed = 0; m_prev = 0; m_level = 0; m_toggle = 0; m_ack = 0;
        end else begin
            bit er, ef;
            er = m_armed && q && !m_prev;
            ef = m_armed && !q && m_prev;
            m_toggle = er || ef;
            m_level  = q;
            if (!m_ack && rd_req) begin
                m_snap_rise[0] = sat_val(m_raw_rise, Max8);
                m_snap_fall[0] = sat_val(m_raw_fall, Max8);
                m_snap_rise[1] = sat_val(m_raw_rise, Max2);
                m_snap_fall[1] = sat_val(m_raw_fall, Max2);
                m_ack = 1;
            end else begin
                m_ack = 0;
            end
            if (clr) begin
                m_raw_rise = 0; m_raw_fall = 0;
            end else begin
                m_raw_rise += int'(er);
                m_raw_fall += int'(ef);
            end
            m_prev  = q;
            m_armed = 1;
        end
    end

    // Compare process: all outputs of both instances every cycle.
    always @(negedge clk) begin
        check("ack8",   int'(ack8),   int'(m_ack));
        check("tog8",   int'(tog8),   int'(m_toggle));
        check("lvl8",   int'(lvl8),   int'(m_level));
        check("sat8",   int'(sat8),   int'(m_raw_rise >= Max8 || m_raw_fall >= Max8));
        check("rsnap8", int'(rsnap8), m_snap_rise[0]);
        check("fsnap8", int'(fsnap8), m_snap_fall[0]);
        check("ack2",   int'(ack2),   int'(m_ack));
        check("tog2",   int'(tog2),   int'(m_toggle));
        check("lvl2",   int'(lvl2),   int'(m_level));
        check("sat2",   int'(sat2),   int'(m_raw_rise >= Max2 || m_raw_fall >= Max2));
        check("rsnap2", int'(rsnap2), m_snap_rise[1]);
        check("fsnap2", int'(fsnap2), m_snap_fall[1]);
    end

    // Apply inputs, let one rising edge sample them, return 2 time units after that edge.
    task automatic drive(input bit qv, input bit cv, input bit rv);
        q = qv; clr = cv; rd_req = rv;
        @(posedge clk);
        #2;
    endtask

    // Produce n rising edges starting and ending with q=0.
    task automatic rises(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Async reset pulse mid-cycle, released 2 units after a later rising edge.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack8",  int'(ack8),   0);
        check("rst_rs8",   int'(rsnap8), 0);
        check("rst_fs8",   int'(fsnap8), 0);
        check("rst_ack2",  int'(ack2),   0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int acks;
        rst_n = 1'b0; q = 1'b0; clr = 1'b0; rd_req = 1'b0;
        #1;
        check("rst_sat8", int'(sat8), 0);
        check("rst_lvl8", int'(lvl8), 0);
        repeat (3) @(posedge clk);
        #2;

        // Release with q held high: no edges, no toggle.
        q = 1'b1;
        rst_n = 1'b1;
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        check("hi_tog", int'(tog8), 0);
        drive(1'b0, 1'b0, 1'b0);
        check("fall_tog", int'(tog8), 1);
        drive(1'b0, 1'b0, 1'b1);
        check("t1_ack", int'(ack8), 1);
        check("t1_rise", int'(rsnap8), 0);
        check("t1_fall", int'(fsnap8), 1);
        drive(1'b0, 1'b0, 1'b0);

        // Pattern 0,1,0,1,1,0 after a clear: two rises, two falls.
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("t2_ack", int'(ack8), 1);
        check("t2_rise", int'(rsnap8), 2);
        check("t2_fall", int'(fsnap8), 2);
        drive(1'b0, 1'b0, 1'b0);

        // Saturation of the 2-bit instance.
        drive(1'b0, 1'b1, 1'b0);
        rises(2);
        drive(1'b1, 1'b0, 1'b0);
        check("t3_sat2", int'(sat2), 1);
        check("t3_sat8", int'(sat8), 0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check("t3_rs2", int'(rsnap2), 3);
        check("t3_rs8", int'(rsnap8), 4);
        drive(1'b1, 1'b1, 1'b0);
        check("t3_clr_sat2", int'(sat2), 0);
        drive(1'b1, 1'b0, 1'b1);
        check("t3_clr_rs2", int'(rsnap2), 0);
        drive(1'b0, 1'b0, 1'b0);

        // Request coincident with a rising edge at rise=5.
        drive(1'b0, 1'b1, 1'b0);
        rises(5);
        drive(1'b1, 1'b0, 1'b1);
        check("t4_rs_a", int'(rsnap8), 5);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check("t4_rs_b", int'(rsnap8), 6);
        drive(1'b0, 1'b0, 1'b0);

        // Clear, rising edge and request in the same cycle at rise=4.
        drive(1'b0, 1'b1, 1'b0);
        rises(4);
        drive(1'b1, 1'b1, 1'b1);
        check("t5_rs_a", int'(rsnap8), 4);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check("t5_rs_b", int'(rsnap8), 0);
        drive(1'b1, 1'b0, 1'b0);

        // Request held for 6 cycles: acks on alternate cycles.
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            acks += int'(ack8);
        end
        check("t6_acks", acks, 3);
        drive(1'b1, 1'b0, 1'b0);
        rises(1);
        drive(1'b0, 1'b0, 1'b1);
        check("t6_ack_pre", int'(ack8), 1);
        reset_pulse();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit qn;
            qn = ($urandom_range(0, 1) == 1) ? ~q : q;
            drive(qn, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 299) == 0) reset_pulse();
        end

        // Long run without clears to saturate the 8-bit instance.
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1200; i++) begin
            drive(~q, 1'b0, ($urandom_range(0, 3) == 0));
        end
        check("t7_sat8", int'(sat8), 1);
        drive(q, 1'b0, 1'b0);
        drive(q, 1'b0, 1'b1);
        check("t7_rs8", int'(rsnap8), 255);
        drive(q, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
